bus_arbiter: RTL and testbench

- Shares the processor's 64-bit external memory/peripheral bus (address, bidirectional data, read, write) between two masters.
- M0 is the processor datapath load/store port. M1 is a DMA/display-refresh engine.
- Sequences each transfer with a programmable wait-state count, returns read data and a one-cycle acknowledge, and stalls the processor while its access is pending.
- Round-robin arbitration on contention.

---
 rtl/bus_arbiter_if.sv | 38 +++
 rtl/bus_arbiter.sv | 137 +++++++++++++
 tb/tb_bus_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Handshake and shared-bus signal bundle for bus_arbiter.
// The master side is the two requesters plus the bus observer; the slave side is the arbiter.
// The tristate data net is kept as a separate top-level port of the arbiter.
interface bus_arbiter_if;
    // M0: processor load/store port
    logic        m0_req;
    logic        m0_we;
    logic [63:0] m0_addr;
    logic [63:0] m0_wdata;
    logic        m0_ack;
    // M1: DMA / display-refresh engine
    logic        m1_req;
    logic        m1_we;
    logic [63:0] m1_addr;
    logic [63:0] m1_wdata;
    logic        m1_ack;
    // Shared results and bus strobes
    logic [63:0] rdata;
    logic        cpu_stall;
    logic [63:0] address;
    logic        read;
    logic        write;
    logic        busy;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m0_ack, m1_ack, rdata, cpu_stall,
        input  address, read, write, busy
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m0_ack, m1_ack, rdata, cpu_stall,
        output address, read, write, busy
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the 64-bit external bus.
// One transfer at a time: IDLE samples the requests, ACCESS holds address and strobe
// for WAIT_CYCLES+1 cycles, ACK pulses the owner's acknowledge, then back to IDLE.
// Ties go to the master that did not win last time. WAIT_CYCLES must be < 2**CNT_W.
module bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic         clock,
    input  logic         reset,
    bus_arbiter_if.slave bus,
    inout  wire [63:0]   data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic [63:0]       addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;
    logic              winner;

    // State register; reset returns to IDLE immediately, aborting any transfer.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Transfer context and registered bus outputs; last_grant starts at 1 so M0 wins the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            read_q       <= read_d;
            write_q      <= write_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
        end
    end

    // Next-state, arbitration and next values of the registered outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        read_d       = 1'b0;
        write_d      = 1'b0;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        winner       = (bus.m0_req && bus.m1_req) ? ~last_grant_q : bus.m1_req;

        unique case (state_q)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    owner_d      = winner;
                    last_grant_d = winner;
                    we_d         = winner ? bus.m1_we    : bus.m0_we;
                    addr_d       = winner ? bus.m1_addr  : bus.m0_addr;
                    wdata_d      = winner ? bus.m1_wdata : bus.m0_wdata;
                    cnt_d        = WAIT_LOAD;
                    read_d       = ~we_d;
                    write_d      = we_d;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) rdata_d = data;
                    m0_ack_d = ~owner_q;
                    m1_ack_d = owner_q;
                    state_d  = ACK;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    read_d  = ~we_q;
                    write_d = we_q;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.address   = addr_q;
    assign bus.read      = read_q;
    assign bus.write     = write_q;
    assign bus.m0_ack    = m0_ack_q;
    assign bus.m1_ack    = m1_ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = (state_q == ACCESS) || (state_q == ACK);
    assign bus.cpu_stall = bus.m0_req & ~m0_ack_q;
    assign data          = write_q ? wdata_q : {64{1'bz}};

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic
// against a transfer-timeline reference model. A second instance runs with zero wait states.
module tb_bus_arbiter;

    localparam int W = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    bus_arbiter_if bif();
    bus_arbiter_if bif0();
    wire [63:0] data;
    wire [63:0] data0;

    bus_arbiter #(.WAIT_CYCLES(W), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .bus(bif), .data(data)
    );

    bus_arbiter #(.WAIT_CYCLES(0), .CNT_W(4)) dut0 (
        .clock(clock), .reset(reset), .bus(bif0), .data(data0)
    );

    // Bus device: returns an address-derived word; address 0x100 returns 0xDEADBEEF.
    function automatic logic [63:0] dev_fn(input logic [63:0] a);
        return ((a - 64'h100) * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0000_0000_DEAD_BEEF;
    endfunction

    assign data = bif.read ? dev_fn(bif.address) : {64{1'bz}};

    int checks = 0;
    int errors = 0;

    // Reference model: one scheduled transfer described by its cycle numbers.
    int          cyc;
    int          acc_s, acc_e, ack_c;
    bit          own, lg, lwe;
    logic [63:0] laddr, lwdata, mrd;
    bit          p_a0, p_a1;

    task automatic model_reset();
        cyc = 0; acc_s = -1; acc_e = -2; ack_c = -1;
        own = 1'b0; lg = 1'b1; lwe = 1'b0;
        laddr = '0; lwdata = '0; mrd = '0;
        p_a0 = 1'b0; p_a1 = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic release_reset();
        next_cycle();
        reset = 1'b0;
        model_reset();
    endtask

    // Predict this cycle's outputs, schedule a grant if the bus is free, then compare at negedge.
    task automatic eval_and_check();
        bit          in_acc, e_rd, e_wr, e_a0, e_a1, e_busy, e_stall;
        logic [63:0] e_addr, e_wd;
        in_acc  = (cyc >= acc_s) && (cyc <= acc_e);
        e_rd    = in_acc && !lwe;
        e_wr    = in_acc && lwe;
        e_a0    = (cyc == ack_c) && !own;
        e_a1    = (cyc == ack_c) && own;
        e_busy  = (cyc >= acc_s) && (cyc <= ack_c);
        e_addr  = laddr;
        e_wd    = lwdata;
        if (cyc == ack_c && !lwe) mrd = dev_fn(laddr);
        e_stall = bif.m0_req && !e_a0;
        if (cyc > ack_c && (bif.m0_req || bif.m1_req)) begin
            own    = (bif.m0_req && bif.m1_req) ? !lg : bif.m1_req;
            lg     = own;
            lwe    = own ? bif.m1_we : bif.m0_we;
            laddr  = own ? bif.m1_addr : bif.m0_addr;
            lwdata = own ? bif.m1_wdata : bif.m0_wdata;
            acc_s  = cyc + 1;
            acc_e  = cyc + 1 + W;
            ack_c  = cyc + 2 + W;
        end
        @(negedge clock);
        checks++;
        if (bif.read !== e_rd) begin
            errors++; $display("FAIL read cyc=%0d got=%b exp=%b", cyc, bif.read, e_rd);
        end
        checks++;
        if (bif.write !== e_wr) begin
            errors++; $display("FAIL write cyc=%0d got=%b exp=%b", cyc, bif.write, e_wr);
        end
        checks++;
        if (bif.m0_ack !== e_a0) begin
            errors++; $display("FAIL m0_ack cyc=%0d got=%b exp=%b", cyc, bif.m0_ack, e_a0);
        end
        checks++;
        if (bif.m1_ack !== e_a1) begin
            errors++; $display("FAIL m1_ack cyc=%0d got=%b exp=%b", cyc, bif.m1_ack, e_a1);
        end
        checks++;
        if (bif.busy !== e_busy) begin
            errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bif.busy, e_busy);
        end
        checks++;
        if (bif.cpu_stall !== e_stall) begin
            errors++; $display("FAIL cpu_stall cyc=%0d got=%b exp=%b", cyc, bif.cpu_stall, e_stall);
        end
        checks++;
        if (bif.rdata !== mrd) begin
            errors++; $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, bif.rdata, mrd);
        end
        if (in_acc) begin
            checks++;
            if (bif.address !== e_addr) begin
                errors++; $display("FAIL address cyc=%0d got=%h exp=%h", cyc, bif.address, e_addr);
            end
        end
        if (e_wr) begin
            checks++;
            if (data !== e_wd) begin
                errors++; $display("FAIL data_wr cyc=%0d got=%h exp=%h", cyc, data, e_wd);
            end
        end else if (!e_rd) begin
            checks++;
            if (data !== 64'h0 && data !== {64{1'bz}}) begin
                errors++; $display("FAIL data_z cyc=%0d got=%h exp=z", cyc, data);
            end
        end
        p_a0 = e_a0;
        p_a1 = e_a1;
        cyc++;
    endtask

    task automatic agents_rand();
        if (!bif.m0_req) begin
            if ($urandom_range(2) == 0) begin
                bif.m0_req = 1'b1; bif.m0_we = 1'($urandom_range(1));
                bif.m0_addr = {$urandom(), $urandom()}; bif.m0_wdata = {$urandom(), $urandom()};
            end
        end else begin
            if ($urandom_range(3) == 0) begin
                bif.m0_we = 1'($urandom_range(1));
                bif.m0_addr = {$urandom(), $urandom()}; bif.m0_wdata = {$urandom(), $urandom()};
            end
            if ($urandom_range(31) == 0) bif.m0_req = 1'b0;
        end
        if (!bif.m1_req) begin
            if ($urandom_range(2) == 0) begin
                bif.m1_req = 1'b1; bif.m1_we = 1'($urandom_range(1));
                bif.m1_addr = {$urandom(), $urandom()}; bif.m1_wdata = {$urandom(), $urandom()};
            end
        end else begin
            if ($urandom_range(3) == 0) begin
                bif.m1_we = 1'($urandom_range(1));
                bif.m1_addr = {$urandom(), $urandom()}; bif.m1_wdata = {$urandom(), $urandom()};
            end
            if ($urandom_range(31) == 0) bif.m1_req = 1'b0;
        end
    endtask

    task automatic step(input bit rnd, input bit drop);
        next_cycle();
        if (drop && p_a0) bif.m0_req = 1'b0;
        if (drop && p_a1) bif.m1_req = 1'b0;
        if (rnd) agents_rand();
        eval_and_check();
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!bif.m0_req && !bif.m1_req && cyc > ack_c) begin
                done = 1'b1;
                break;
            end
            step(1'b0, 1'b1);
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL drain_timeout got=busy exp=idle within 200 cycles");
        end
    endtask

    task automatic test_reset();
        bif.m0_req = 1'b1; bif.m0_we = 1'b0; bif.m0_addr = 64'h40; bif.m0_wdata = 64'h1;
        bif.m1_req = 1'b0; bif.m1_we = 1'b0; bif.m1_addr = '0; bif.m1_wdata = '0;
        bif0.m0_req = 1'b0; bif0.m0_we = 1'b0; bif0.m0_addr = '0; bif0.m0_wdata = '0;
        bif0.m1_req = 1'b0; bif0.m1_we = 1'b0; bif0.m1_addr = '0; bif0.m1_wdata = '0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if (bif.read !== 1'b0 || bif.write !== 1'b0) begin
            errors++; $display("FAIL reset_strobes got=%b%b exp=00", bif.read, bif.write);
        end
        checks++;
        if (bif.m0_ack !== 1'b0 || bif.m1_ack !== 1'b0 || bif.busy !== 1'b0) begin
            errors++; $display("FAIL reset_ack_busy got=%b%b%b exp=000", bif.m0_ack, bif.m1_ack, bif.busy);
        end
        checks++;
        if (bif.address !== 64'h0 || bif.rdata !== 64'h0) begin
            errors++; $display("FAIL reset_regs got=%h/%h exp=0/0", bif.address, bif.rdata);
        end
        checks++;
        if (data !== 64'h0 && data !== {64{1'bz}}) begin
            errors++; $display("FAIL reset_data got=%h exp=z", data);
        end
        checks++;
        if (bif.cpu_stall !== 1'b1) begin
            errors++; $display("FAIL reset_stall got=%b exp=1", bif.cpu_stall);
        end
        release_reset();
        eval_and_check();
        step(1'b0, 1'b1);
        checks++;
        if (bif.read !== 1'b1 || bif.address !== 64'h40) begin
            errors++; $display("FAIL first_grant got=%b/%h exp=1/40", bif.read, bif.address);
        end
        drain();
    endtask

    task automatic test_m0_read();
        int          rd_cnt, stall_cnt, ack_at;
        logic [63:0] ack_rd;
        drain();
        next_cycle();
        bif.m0_req = 1'b1; bif.m0_we = 1'b0; bif.m0_addr = 64'h100; bif.m0_wdata = {$urandom(), $urandom()};
        eval_and_check();
        rd_cnt = 0; stall_cnt = (bif.cpu_stall === 1'b1) ? 1 : 0; ack_at = -1; ack_rd = '0;
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 1'b1);
            if (bif.read === 1'b1 && bif.address === 64'h100) rd_cnt++;
            if (bif.cpu_stall === 1'b1) stall_cnt++;
            if (bif.m0_ack === 1'b1 && ack_at < 0) begin ack_at = k; ack_rd = bif.rdata; end
        end
        checks++;
        if (rd_cnt != W + 1) begin
            errors++; $display("FAIL m0_read_strobe_cycles got=%0d exp=%0d", rd_cnt, W + 1);
        end
        checks++;
        if (ack_at != W + 2) begin
            errors++; $display("FAIL m0_read_ack_cycle got=%0d exp=%0d", ack_at, W + 2);
        end
        checks++;
        if (ack_rd !== 64'hDEAD_BEEF) begin
            errors++; $display("FAIL m0_read_rdata got=%h exp=deadbeef", ack_rd);
        end
        checks++;
        if (stall_cnt != W + 2) begin
            errors++; $display("FAIL m0_read_stall_cycles got=%0d exp=%0d", stall_cnt, W + 2);
        end
    endtask

    task automatic test_m1_write();
        int wr_cnt, ack_at, m0_acks;
        bit ack_dz;
        drain();
        next_cycle();
        bif.m1_req = 1'b1; bif.m1_we = 1'b1; bif.m1_addr = 64'h2000; bif.m1_wdata = 64'h55;
        eval_and_check();
        wr_cnt = 0; ack_at = -1; m0_acks = 0; ack_dz = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 1'b1);
            if (bif.write === 1'b1 && bif.address === 64'h2000 && data === 64'h55) wr_cnt++;
            if (bif.m0_ack === 1'b1) m0_acks++;
            if (bif.m1_ack === 1'b1 && ack_at < 0) begin
                ack_at = k;
                ack_dz = (data === 64'h0) || (data === {64{1'bz}});
            end
        end
        checks++;
        if (wr_cnt != W + 1) begin
            errors++; $display("FAIL m1_write_cycles got=%0d exp=%0d", wr_cnt, W + 1);
        end
        checks++;
        if (ack_at != W + 2 || m0_acks != 0) begin
            errors++; $display("FAIL m1_write_ack got=%0d/%0d exp=%0d/0", ack_at, m0_acks, W + 2);
        end
        checks++;
        if (!ack_dz) begin
            errors++; $display("FAIL m1_write_data_in_ack got=driven exp=z");
        end
    endtask

    task automatic test_round_robin();
        int order[4];
        int at[4];
        int n;
        next_cycle();
        reset = 1'b1;
        bif.m0_req = 1'b1; bif.m0_we = 1'b0; bif.m0_addr = 64'hA0;   bif.m0_wdata = 64'h11;
        bif.m1_req = 1'b1; bif.m1_we = 1'b1; bif.m1_addr = 64'hB000; bif.m1_wdata = 64'h22;
        release_reset();
        eval_and_check();
        n = 0;
        for (int i = 1; i < 60; i++) begin
            if (n == 4) break;
            step(1'b0, 1'b0);
            if (bif.m0_ack === 1'b1 || bif.m1_ack === 1'b1) begin
                order[n] = (bif.m1_ack === 1'b1) ? 1 : 0;
                at[n] = i;
                n++;
            end
        end
        next_cycle();
        bif.m0_req = 1'b0; bif.m1_req = 1'b0;
        eval_and_check();
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL rr_ack_count got=%0d exp=4", n);
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (order[j] != (j % 2) || at[j] != (W + 2) + j * (W + 3)) begin
                    errors++;
                    $display("FAIL rr_grant_%0d got=M%0d@%0d exp=M%0d@%0d", j, order[j], at[j], j % 2, (W + 2) + j * (W + 3));
                end
            end
        end
    endtask

    task automatic test_wait0();
        logic [63:0] wd;
        logic [3:0]  wr_mask;
        int          ack_at;
        logic [63:0] wdat;
        bit          stall0;
        drain();
        wd = {$urandom(), $urandom()};
        next_cycle();
        bif0.m0_req = 1'b1; bif0.m0_we = 1'b1; bif0.m0_addr = 64'h8; bif0.m0_wdata = wd;
        @(negedge clock);
        wr_mask = {3'b000, bif0.write};
        stall0 = bif0.cpu_stall;
        ack_at = -1; wdat = '0;
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            if (ack_at > 0) bif0.m0_req = 1'b0;
            @(negedge clock);
            wr_mask[k] = bif0.write;
            if (bif0.write === 1'b1) wdat = data0;
            if (bif0.m0_ack === 1'b1 && ack_at < 0) ack_at = k;
        end
        checks++;
        if (wr_mask !== 4'b0010) begin
            errors++; $display("FAIL w0_write_cycles got=%b exp=0010", wr_mask);
        end
        checks++;
        if (ack_at != 2) begin
            errors++; $display("FAIL w0_ack_cycle got=%0d exp=2", ack_at);
        end
        checks++;
        if (wdat !== wd || stall0 !== 1'b1) begin
            errors++; $display("FAIL w0_data_stall got=%h/%b exp=%h/1", wdat, stall0, wd);
        end
    endtask

    task automatic test_reset_abort();
        int acks;
        drain();
        next_cycle();
        bif.m1_req = 1'b1; bif.m1_we = 1'b0; bif.m1_addr = {$urandom(), $urandom()}; bif.m1_wdata = '0;
        eval_and_check();
        step(1'b0, 1'b1);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (bif.read !== 1'b0 || bif.write !== 1'b0 || bif.busy !== 1'b0) begin
            errors++; $display("FAIL abort_strobes got=%b%b%b exp=000", bif.read, bif.write, bif.busy);
        end
        checks++;
        if (bif.m1_ack !== 1'b0 || bif.rdata !== 64'h0) begin
            errors++; $display("FAIL abort_ack_rdata got=%b/%h exp=0/0", bif.m1_ack, bif.rdata);
        end
        bif.m1_req = 1'b0;
        release_reset();
        eval_and_check();
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1);
            if (bif.m1_ack === 1'b1 || bif.busy === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++; $display("FAIL abort_no_ack got=%0d exp=0", acks);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) step(1'b1, 1'b1);
        drain();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_m0_read();
        test_m1_write();
        test_round_robin();
        test_wait0();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
